// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
//   - NOP encoding and PC increment used by the fetch stage
//   - forwarding-select encodings shared with the hazard/forwarding unit
//   - IF/ID register layout and a word-alignment helper
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  // Instruction addresses are word aligned; the two low bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter used for the fetch-stage performance counters.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset, clears the count
//   inc_i   - increment request for this cycle
//   count_o - current count; sticks at all-ones
module mips_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic at_max;

  assign at_max = (count_o == {W{1'b1}});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && !at_max) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// IF stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
// Owns the PC, drives the instruction-memory address and latches the fetched
// instruction with its PC+4 for decode. Redirects from EX squash the
// wrong-path fetch with a bubble; load-use stalls freeze PC and IF/ID.
// Ports:
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   stall_i             - load-use stall from the hazard unit
//   redirect_i          - taken branch/jump resolved in EX
//   redirect_target_i   - branch/jump target
//   imem_rdata_i        - instruction at imem_addr_o (combinational memory)
//   imem_addr_o, pc_o   - current PC
//   if_id_instr_o/pc4_o/valid_o - IF/ID register contents
//   stall_count_o, flush_count_o - saturating performance counters
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_target_i,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      imem_addr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic [31:0]      if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  if_id_t      if_id_q;
  logic        stall_inc;
  logic        flush_inc;

  // Wraps modulo 2^32 with no indication.
  assign pc_plus4 = pc_q + PC_STEP;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      if_id_q <= IF_ID_BUBBLE;
    end else if (redirect_i) begin
      // Redirect wins over stall: the stalled instruction is on the wrong path.
      pc_q    <= align_word(redirect_target_i);
      if_id_q <= IF_ID_BUBBLE;
    end else if (!stall_i) begin
      pc_q    <= pc_plus4;
      if_id_q <= '{instr: imem_rdata_i, pc4: pc_plus4, valid: 1'b1};
    end
  end

  // A stall coinciding with a redirect is dropped, so it is not counted.
  assign stall_inc = stall_i & ~redirect_i;
  assign flush_inc = redirect_i;

  mips_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_inc),
    .count_o (stall_count_o)
  );

  mips_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_inc),
    .count_o (flush_count_o)
  );

  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign if_id_valid_o = if_id_q.valid;

endmodule

// File: tb/tb_mips_fetch_stage.sv
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] target;

  logic [31:0] imem_addr, pc, instr, pc4;
  logic        valid;
  logic [15:0] scnt, fcnt;
  logic [31:0] imem_rdata;

  logic [31:0] imem_addr_s, pc_s, instr_s, pc4_s, imem_rdata_s;
  logic        valid_s;
  logic [3:0]  scnt_s, fcnt_s;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic [3:0]  scnt_s;
    logic [3:0]  fcnt_s;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_scnt, m_fcnt;
  logic [3:0]  m_scnt_s, m_fcnt_s;

  always #5 clk = ~clk;

  assign imem_rdata   = 32'hAAAA_0000 + imem_addr;
  assign imem_rdata_s = 32'hAAAA_0000 + imem_addr_s;

  mips_fetch_stage #(.RESET_PC(32'h100), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_target_i(target), .imem_rdata_i(imem_rdata),
    .imem_addr_o(imem_addr), .pc_o(pc), .if_id_instr_o(instr),
    .if_id_pc4_o(pc4), .if_id_valid_o(valid),
    .stall_count_o(scnt), .flush_count_o(fcnt)
  );

  mips_fetch_stage #(.RESET_PC(32'h100), .CNT_W(4)) dut_small (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_target_i(target), .imem_rdata_i(imem_rdata_s),
    .imem_addr_o(imem_addr_s), .pc_o(pc_s), .if_id_instr_o(instr_s),
    .if_id_pc4_o(pc4_s), .if_id_valid_o(valid_s),
    .stall_count_o(scnt_s), .flush_count_o(fcnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h100; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_scnt = '0; m_fcnt = '0; m_scnt_s = '0; m_fcnt_s = '0;
  endtask

  task automatic check_now(input string tag);
    check({tag, ".pc"},        pc,        m_pc);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
    check({tag, ".instr"},     instr,     m_instr);
    check({tag, ".pc4"},       pc4,       m_pc4);
    check({tag, ".valid"},     {31'b0, valid}, {31'b0, m_valid});
    check({tag, ".scnt"},      {16'b0, scnt},  {16'b0, m_scnt});
    check({tag, ".fcnt"},      {16'b0, fcnt},  {16'b0, m_fcnt});
    check({tag, ".scnt_s"},    {28'b0, scnt_s}, {28'b0, m_scnt_s});
    check({tag, ".pc_s"},      pc_s,      m_pc);
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare
  // the DUT against the popped entry just after the rising edge.
  task automatic cycle(input string tag, input logic st, input logic rd, input logic [31:0] tgt);
    exp_t e;
    stall = st; redirect = rd; target = tgt;
    if (rd) begin
      m_pc = {tgt[31:2], 2'b00};
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_fcnt != 16'hFFFF) m_fcnt++;
      if (m_fcnt_s != 4'hF) m_fcnt_s++;
    end else if (st) begin
      if (m_scnt != 16'hFFFF) m_scnt++;
      if (m_scnt_s != 4'hF) m_scnt_s++;
    end else begin
      m_instr = 32'hAAAA_0000 + m_pc;
      m_pc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    e = '{m_pc, m_instr, m_pc4, m_valid, m_scnt, m_fcnt, m_scnt_s, m_fcnt_s};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".pc"},        pc,        e.pc);
      check({tag, ".imem_addr"}, imem_addr, e.pc);
      check({tag, ".instr"},     instr,     e.instr);
      check({tag, ".pc4"},       pc4,       e.pc4);
      check({tag, ".valid"},     {31'b0, valid}, {31'b0, e.valid});
      check({tag, ".scnt"},      {16'b0, scnt},  {16'b0, e.scnt});
      check({tag, ".fcnt"},      {16'b0, fcnt},  {16'b0, e.fcnt});
      check({tag, ".scnt_s"},    {28'b0, scnt_s}, {28'b0, e.scnt_s});
      check({tag, ".fcnt_s"},    {28'b0, fcnt_s}, {28'b0, e.fcnt_s});
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_now("reset");
    rst = 1'b0;

    // Free-running fetch from RESET_PC
    cycle("free0", 0, 0, 32'h0);
    check("free0.first_instr", instr, 32'hAAAA_0100);
    check("free0.first_pc4",   pc4,   32'h104);
    cycle("free1", 0, 0, 32'h0);

    // Stall at pc=0x108 for 3 cycles, then release
    check("stall.start_pc", pc, 32'h108);
    for (int i = 0; i < 3; i++) cycle("stall", 1, 0, 32'h0);
    check("stall.count3", {16'b0, scnt}, 32'd3);
    cycle("release", 0, 0, 32'h0);
    check("release.pc", pc, 32'h10C);

    // Redirect with a simultaneous stall and unaligned target
    cycle("redir_stall", 1, 1, 32'h2003);
    check("redir_stall.pc", pc, 32'h2000);
    cycle("after_redir", 0, 0, 32'h0);

    // Back-to-back redirects
    cycle("b2b0", 0, 1, 32'h3000);
    cycle("b2b1", 0, 1, 32'h4001);
    cycle("b2b2", 1, 1, 32'h5002);

    // PC wrap at the top of the address space
    cycle("wrap_redir", 0, 1, 32'hFFFF_FFFC);
    cycle("wrap_free", 0, 0, 32'h0);
    check("wrap.pc",  pc,  32'h0);
    check("wrap.pc4", pc4, 32'h0);
    cycle("wrap_free2", 0, 0, 32'h0);

    // Long stall ended by a redirect
    for (int i = 0; i < 5; i++) cycle("long_stall", 1, 0, 32'h0);
    cycle("stall_redir", 1, 1, 32'h0000_0800);
    cycle("post_stall_redir", 0, 0, 32'h0);

    // Async reset mid-cycle during a stall, no clock edge in between
    stall = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_now("async_rst");
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    cycle("post_rst", 0, 0, 32'h0);

    // Counter saturation: 20 stall cycles on the 4-bit instance
    for (int i = 0; i < 20; i++) cycle("sat", 1, 0, 32'h0);
    check("sat.small", {28'b0, scnt_s}, 32'd15);
    check("sat.big",   {16'b0, scnt},   32'd20);
    cycle("sat_hold", 1, 0, 32'h0);
    check("sat_hold.small", {28'b0, scnt_s}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
IF stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 into IF/ID for the decode stage, where the hazard/forwarding unit examines rs/rt.
- Consumes that unit's load-use stall and the EX-stage branch/jump redirect; squashes wrong-path fetches with a NOP bubble.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
stall_i  input  1  load-use stall from hazard unit; freeze PC and IF/ID
redirect_i  input  1  taken branch/jump resolved in EX; fetch from redirect_target_i
redirect_target_i  input  32  branch/jump target address
imem_rdata_i  input  32  instruction word at imem_addr_o (combinational read)
imem_addr_o  output  32  instruction-memory address, equals current PC
pc_o  output  32  current PC register
if_id_instr_o  output  32  IF/ID instruction
if_id_pc4_o  output  32  IF/ID PC+4 of that instruction
if_id_valid_o  output  1  IF/ID holds a real (non-bubble) instruction
stall_count_o  output  CNT_W  cycles spent stalled, saturating
flush_count_o  output  CNT_W  redirects taken, saturating

Behaviour:
- Reset (async assert, any cycle):
  - pc = RESET_PC.
  - if_id_instr = NOP (32'h0), if_id_pc4 = 0, if_id_valid = 0.
  - Both counters = 0.
  - Deassertion takes effect at the next rising edge; the first fetch address is RESET_PC.
- imem_addr_o = pc_o, combinational from the PC register; no extra latency. An instruction fetched in cycle N appears on if_id_* in cycle N+1.
- Priority per rising edge is redirect_i > stall_i > normal.
- Redirect (redirect_i=1, regardless of stall_i):
  - pc <= {redirect_target_i[31:2], 2'b00}; low target bits are silently discarded.
  - IF/ID <= NOP, pc4 = 0, valid = 0; this squashes the wrong-path instruction.
  - flush_count++.
  - A stall in the same cycle is dropped, because the stalled instruction is being squashed.
- Stall (stall_i=1, redirect_i=0):
  - pc and all IF/ID fields hold their values.
  - stall_count++.
  - imem_rdata_i is ignored.
- Normal (both 0):
  - pc <= pc + 4.
  - IF/ID <= {imem_rdata_i, pc + 4, valid = 1}.
- PC arithmetic is modulo 2^32: pc = 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Counters saturate at all-ones and never wrap.
- Back-to-back redirects: each one loads a new target and inserts another bubble; flush_count increments each cycle.
- Stall held for many cycles: state is frozen indefinitely and stall_count keeps counting until saturation.
- A redirect arriving during a long stall ends the stall immediately.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0000_0000.
  - PC_STEP = 4.
  - Forwarding-select encodings FWD_NONE = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10, shared with the hazard unit.
- One sub-module: mips_sat_counter (parameter W; ports clk_i, rst_i, inc_i, count_o), instantiated twice for the performance counters.
- The PC register and the IF/ID register stay in the top module.

Test Plan:
1. Reset with RESET_PC=0x100, release, imem returns 0xAAAA0000+addr, 3 free cycles -> imem_addr 0x100, 0x104, 0x108; IF/ID instr 0xAAAA0100 with pc4 0x104 and valid=1 one cycle after each fetch.
2. stall_i high 3 cycles at pc=0x108 -> pc_o stays 0x108 and IF/ID unchanged all 3 cycles; stall_count_o=3; after release pc advances to 0x10C.
3. redirect_i=1 and stall_i=1 in the same cycle, target 0x2003 -> next pc_o = 0x2000, if_id_valid=0, if_id_instr=0, flush_count=1, stall_count unchanged.
4. Wrap: redirect to 0xFFFFFFFC, one free cycle -> pc_o = 0x00000000 and if_id_pc4 = 0x00000000.
5. Async reset asserted mid-cycle during a stall -> outputs reach reset values immediately without a clock edge; counters=0.
6. CNT_W=4, 20 stall cycles -> stall_count_o saturates at 15 and holds.
